// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter and sequencer for a shared NUM_REQ-input mux. It picks
//   one requester fairly, drives the mux select, and forwards that requester's
//   data as a valid/ready stream for up to MAX_BURST beats. Then it returns to
//   IDLE and arbitrates again, starting from the requester after the winner.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   req       per-requester request/valid
//   in        packed requester data, requester k at in[k*DATA_W +: DATA_W]
//   gnt       one-hot grant (registered)
//   s         mux select, index of granted requester (registered)
//   op        selected data while op_valid, else 0
//   op_valid  beat present on op
//   op_ready  consumer accepts the beat
//   busy      high while a grant is active
//
// state | meaning
// IDLE  | no grant; choose the next winner from ptr onward
// GRANT | requester s owns the mux; beats flow until the burst ends or req drops

module mux_rr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int SEL_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          s,
  output logic [DATA_W-1:0]         op,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic                      busy
);

  // Keep the counter at least one bit wide so MAX_BURST=1 still elaborates.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   pick;
  logic               found;
  logic [DATA_W-1:0]  in_words [NUM_REQ];
  logic               xfer;
  logic               grant_end;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign in_words[k] = in[k*DATA_W +: DATA_W];
  end

  // Walk the offsets from far to near so the nearest requester at or after
  // ptr is the last one written. NUM_REQ is a power of two, so the SEL_W-bit
  // add wraps modulo NUM_REQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        pick  = ptr + SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  assign busy     = (state == GRANT);
  assign op_valid = busy && req[s];
  assign op       = op_valid ? in_words[s] : '0;
  assign xfer     = op_valid && op_ready;

  // A withdrawn request ends the grant even though no beat moves on that edge.
  assign grant_end = busy && (!req[s] || (xfer && (cnt == CNT_LAST)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      s     <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            s     <= pick;
            gnt   <= NUM_REQ'(1) << pick;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (grant_end) begin
            // s is left alone so the last winner stays visible on the select.
            ptr   <= s + SEL_W'(1);
            gnt   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (xfer) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] in_bus;
  logic [N-1:0]  gnt;
  logic [SW-1:0] s;
  logic [DW-1:0] op;
  logic          op_valid;
  logic          op_ready;
  logic          busy;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .in       (in_bus),
    .gnt      (gnt),
    .s        (s),
    .op       (op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .busy     (busy)
  );

  logic [DW-1:0] word [N];
  int n_cmp = 0;
  int n_err = 0;

  // reference: who owns the mux, beats delivered so far, where the search starts
  bit m_busy;
  int m_owner, m_s, m_beats, m_ptr;

  // what the DUT was seen to do, for per-scenario checks
  int cyc = 0;
  int q_order[$];
  int q_beats[$];
  int q_start[$];
  logic [N-1:0] prev_gnt;
  int beat_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic rdy, input logic rs);
    if (rs) begin
      m_busy = 0; m_ptr = 0; m_s = 0; m_beats = 0; m_owner = 0;
    end else if (!m_busy) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (r[k]) begin
          m_busy = 1; m_owner = k; m_s = k; m_beats = 0;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
    end else if (rdy) begin
      m_beats++;
      if (m_beats == MB) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic rdy, input logic rs);
    logic [N-1:0]  e_gnt;
    logic          e_valid;
    logic [DW-1:0] e_op;
    @(negedge clk);
    req = r; op_ready = rdy; rst = rs;
    for (int i = 0; i < N; i++) in_bus[i*DW +: DW] = word[i];
    #1;
    e_gnt   = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e_valid = m_busy && r[m_owner];
    e_op    = e_valid ? word[m_owner] : '0;
    chk("gnt", gnt, e_gnt);
    chk("s", s, m_s);
    chk("op_valid", op_valid, e_valid);
    chk("op", op, e_op);
    chk("busy", busy, m_busy);
    if (gnt != 0 && prev_gnt == 0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) q_order.push_back(i);
      q_start.push_back(cyc);
      beat_acc = 0;
    end
    if (gnt == 0 && prev_gnt != 0) q_beats.push_back(beat_acc);
    if (gnt != 0 && !rs && op_valid && rdy) beat_acc++;
    prev_gnt = gnt;
    cyc++;
    @(posedge clk);
    model_edge(r, rdy, rs);
  endtask

  task automatic do_reset();
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    q_order.delete(); q_beats.delete(); q_start.delete();
  endtask

  task automatic chk_list(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk(tag, got[i], exp[i]);
  endtask

  initial begin
    logic [N-1:0] rr;
    logic rdy, rs;
    rst = 1'b1; req = '0; op_ready = 1'b0; in_bus = '0;
    prev_gnt = '0; beat_acc = 0;
    for (int i = 0; i < N; i++) word[i] = '0;
    repeat (2) @(posedge clk);
    model_edge('0, 1'b0, 1'b1);

    // reset then idle
    do_reset();
    repeat (10) cycle(4'b0000, 1'b1, 1'b0);

    // single requester, two back-to-back grants
    do_reset();
    word[2] = 8'hA5;
    repeat (11) cycle(4'b0100, 1'b1, 1'b0);
    chk_list("single_order", q_order, '{2, 2});
    chk_list("single_beats", q_beats, '{4, 4});
    if (q_start.size() >= 2) chk("single_gap", q_start[1] - q_start[0], 5);

    // full contention
    do_reset();
    for (int i = 0; i < N; i++) word[i] = 8'h10 + 8'(i);
    repeat (25) cycle(4'b1111, 1'b1, 1'b0);
    chk_list("rr_order", q_order, '{0, 1, 2, 3, 0});
    chk_list("rr_beats", q_beats, '{4, 4, 4, 4});
    for (int i = 1; i < q_start.size(); i++) chk("rr_gap", q_start[i] - q_start[i-1], 5);

    // backpressure after beat 2
    do_reset();
    word[0] = 8'h3C;
    repeat (3) cycle(4'b0001, 1'b1, 1'b0);
    repeat (7) cycle(4'b0001, 1'b0, 1'b0);
    repeat (3) cycle(4'b0001, 1'b1, 1'b0);
    chk_list("bp_beats", q_beats, '{4});

    // withdrawal with pointer wrap
    do_reset();
    word[0] = 8'h5A; word[2] = 8'hC3; word[3] = 8'h77;
    repeat (5) cycle(4'b0100, 1'b1, 1'b0);
    repeat (2) cycle(4'b1001, 1'b1, 1'b0);
    repeat (6) cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    chk_list("wd_order", q_order, '{2, 3, 0});
    chk_list("wd_beats", q_beats, '{4, 1, 4});

    // reset mid-burst
    do_reset();
    word[1] = 8'h96;
    repeat (2) cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b1);
    repeat (6) cycle(4'b0010, 1'b1, 1'b0);
    chk_list("rst_order", q_order, '{1, 1});
    chk_list("rst_beats", q_beats, '{1, 4});

    // randomized traffic against the reference
    do_reset();
    rr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        word[i] = 8'($urandom);
        if (rr[i]) begin
          if ($urandom_range(0, 19) == 0) rr[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rr[i] = 1'b1;
        end
      end
      rdy = ($urandom_range(0, 9) < 7);
      rs  = ($urandom_range(0, 199) == 0);
      cycle(rr, rdy, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
